// File: rtl/instr_loader_pkg.sv
// Shared types and sizing helpers for the instruction image loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    localparam int unsigned HDR_BYTES = 4;

    function automatic int unsigned max_words(input int unsigned addr_width);
        return (32'd1 << addr_width) / 32'd4;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input plus instruction-memory write port of the loader.
interface instr_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [7:0]            in_byte;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  in_valid, in_byte,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output in_valid, in_byte,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_loader_byte_assembler.sv
// Purpose: packs 4 little-endian bytes into a word; lane chosen by a 2-bit counter.
// Latency: word_nxt/word_valid are combinational in the cycle of the 4th byte.
// Backpressure: none; only advances on xfer, which the parent qualifies.
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        xfer,
    input  logic [7:0]  in_byte,
    output logic [31:0] word_nxt,
    output logic        word_valid
);
    logic [3:0][7:0] lanes;
    logic [3:0][7:0] lanes_nxt;
    logic [1:0]      byte_cnt;

    always_comb begin
        lanes_nxt           = lanes;
        lanes_nxt[byte_cnt] = in_byte;
    end

    assign word_nxt   = lanes_nxt;
    assign word_valid = xfer && (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes    <= '0;
            byte_cnt <= 2'd0;
        end else if (clr) begin
            lanes    <= '0;
            byte_cnt <= 2'd0;
        end else if (xfer) begin
            lanes    <= lanes_nxt;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/instr_loader.sv
// Purpose: loads a length/payload/checksum byte frame into instruction memory, holding the CPU until verified.
// Latency: last payload byte -> wr_en next cycle; checksum byte -> load_done/load_err/cpu_hold next cycle.
// Backpressure: in_ready high only in LEN/DATA/CSUM; memory writes never stall the stream.
module instr_loader
    import loader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    instr_loader_if.master        bus,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);
    localparam int unsigned MAX_W = max_words(ADDR_WIDTH);

    loader_state_t         state;
    logic [31:0]           n_words;
    logic [31:0]           word_idx;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [7:0]            sum;

    logic                  xfer;
    logic                  arm;
    logic [DATA_WIDTH-1:0] word_nxt;
    logic                  word_valid;

    assign xfer = bus.in_valid && bus.in_ready;
    assign arm  = start && (state == IDLE || state == DONE || state == ERR);

    // Header and payload share one assembler; its counter wraps to 0 after the header.
    byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (arm),
        .xfer       (xfer),
        .in_byte    (bus.in_byte),
        .word_nxt   (word_nxt),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            n_words      <= '0;
            word_idx     <= '0;
            next_addr    <= '0;
            sum          <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (arm) begin
                        state        <= LEN;
                        bus.in_ready <= 1'b1;
                        cpu_hold     <= 1'b1;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                        word_idx     <= '0;
                        next_addr    <= BASE_ADDR;
                        sum          <= '0;
                    end
                end
                LEN: begin
                    if (word_valid) begin
                        n_words <= word_nxt;
                        if (word_nxt > MAX_W) begin
                            state        <= ERR;
                            load_err     <= 1'b1;
                            bus.in_ready <= 1'b0;
                        end else if (word_nxt == 32'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        sum <= sum + bus.in_byte;
                    end
                    if (word_valid) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= next_addr;
                        bus.wr_data <= word_nxt;
                        next_addr   <= next_addr + ADDR_WIDTH'(4);
                        word_idx    <= word_idx + 32'd1;
                        if (word_idx == n_words - 32'd1) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        bus.in_ready <= 1'b0;
                        if (bus.in_byte == sum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Scoreboarded bench: stimulus pushes expected memory writes, a negedge monitor pops and compares.
module tb_instr_loader;
    import loader_pkg::*;

    localparam int AW    = 12;
    localparam int MAXW  = (1 << AW) / 4;
    localparam logic [AW-1:0] BASE = 12'h000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, load_done, load_err;

    instr_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    logic [31:0]   img[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && bus.wr_en) begin
            if (exp_addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wr got addr=%0h data=%0h exp=none", bus.wr_addr, bus.wr_data);
            end else begin
                chk("wr_addr", 64'(bus.wr_addr), 64'(exp_addr_q.pop_front()));
                chk("wr_data", 64'(bus.wr_data), 64'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int guard;
        while (stall && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_byte  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout got=0 exp=1");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] n, input logic [7:0] csum, input bit stall);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) send_byte(n[8*j +: 8], stall);
        for (int k = 0; k < img.size(); k++) begin
            w = img[k];
            for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], stall);
        end
        send_byte(csum, stall);
    endtask

    // Reference: image words go to consecutive word addresses; checksum is the byte sum.
    function automatic logic [7:0] model_push();
        int unsigned s = 0;
        for (int k = 0; k < img.size(); k++) begin
            exp_addr_q.push_back(AW'(int'(BASE) + 4 * k));
            exp_data_q.push_back(img[k]);
            for (int j = 0; j < 4; j++) s += (img[k] >> (8 * j)) & 32'hff;
        end
        return 8'(s % 256);
    endfunction

    task automatic check_end(input string nm, input bit ok);
        chk({nm, "_done"}, 64'(load_done), 64'(ok));
        chk({nm, "_err"},  64'(load_err),  64'(!ok));
        chk({nm, "_hold"}, 64'(cpu_hold),  64'(!ok));
        chk({nm, "_rdy"},  64'(bus.in_ready), 64'(0));
        chk({nm, "_pend"}, 64'(exp_addr_q.size()), 64'(0));
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_rdy"},   64'(bus.in_ready), 64'(0));
        chk({nm, "_wren"},  64'(bus.wr_en),    64'(0));
        chk({nm, "_waddr"}, 64'(bus.wr_addr),  64'(0));
        chk({nm, "_wdata"}, 64'(bus.wr_data),  64'(0));
        chk({nm, "_hold"},  64'(cpu_hold),     64'(1));
        chk({nm, "_done"},  64'(load_done),    64'(0));
        chk({nm, "_err"},   64'(load_err),     64'(0));
    endtask

    initial begin
        logic [7:0] cs;
        bit corrupt;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;

        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;

        // Bytes offered while idle are ignored.
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hA5;
        repeat (3) @(negedge clk);
        chk("idle_rdy", 64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b0;

        // Directed good frame.
        img = '{32'h00500513, 32'h00100593};
        exp_addr_q.push_back(12'h000); exp_data_q.push_back(32'h00500513);
        exp_addr_q.push_back(12'h004); exp_data_q.push_back(32'h00100593);
        pulse_start();
        send_frame(32'd2, 8'h10, 1'b0);
        check_end("good", 1'b1);

        // Re-arm from DONE brings the hold back next cycle.
        pulse_start();
        chk("rearm_hold", 64'(cpu_hold), 64'(1));
        chk("rearm_done", 64'(load_done), 64'(0));
        exp_addr_q.push_back(12'h000); exp_data_q.push_back(32'h00500513);
        exp_addr_q.push_back(12'h004); exp_data_q.push_back(32'h00100593);
        send_frame(32'd2, 8'h11, 1'b0);
        check_end("badcs", 1'b0);

        // Recover from ERR with a stalled good frame.
        exp_addr_q.push_back(12'h000); exp_data_q.push_back(32'h00500513);
        exp_addr_q.push_back(12'h004); exp_data_q.push_back(32'h00100593);
        pulse_start();
        send_frame(32'd2, 8'h10, 1'b1);
        check_end("stall", 1'b1);

        // Empty image.
        img = {};
        pulse_start();
        send_frame(32'd0, 8'h00, 1'b0);
        check_end("empty", 1'b1);

        // Length overflow.
        pulse_start();
        begin
            logic [31:0] n;
            n = 32'(MAXW + 1);
            for (int j = 0; j < 4; j++) send_byte(n[8*j +: 8], 1'b0);
        end
        chk("ovf_err",  64'(load_err),     64'(1));
        chk("ovf_rdy",  64'(bus.in_ready), 64'(0));
        chk("ovf_done", 64'(load_done),    64'(0));
        chk("ovf_hold", 64'(cpu_hold),     64'(1));

        // Randomized frames against the model.
        for (int it = 0; it < 6; it++) begin
            img = {};
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) img.push_back($urandom);
            cs = model_push();
            corrupt = ($urandom_range(0, 2) == 0);
            if (corrupt) cs = cs + 8'(1 + $urandom_range(0, 254));
            pulse_start();
            send_frame(32'(img.size()), cs, bit'($urandom_range(0, 1)));
            check_end("rand", !corrupt);
        end

        // Reset after 6 payload bytes: one write, partial word dropped.
        img = '{32'hDEADBEEF, 32'h12345678};
        exp_addr_q.push_back(12'h000); exp_data_q.push_back(32'hDEADBEEF);
        pulse_start();
        begin
            logic [31:0] n;
            logic [31:0] w;
            n = 32'd2;
            for (int j = 0; j < 4; j++) send_byte(n[8*j +: 8], 1'b0);
            w = img[0];
            for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b0);
            w = img[1];
            for (int j = 0; j < 2; j++) send_byte(w[8*j +: 8], 1'b0);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        chk("rst_pend",  64'(exp_addr_q.size()), 64'(0));
        chk("rst_rdy",   64'(bus.in_ready), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
